// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and sizing helper for the parametrised register file.
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    function automatic int rf_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: zeroing sweep sequencer; walks every entry after reset or on ClearReq.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ClearReq,
    output logic                 ClrEn,
    output logic [ADDR_BITS-1:0] ClrAddr,
    output logic                 Ready
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(rf_depth(ADDR_BITS) - 1);

    rf_state_e            state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;

    // The counter wraps to 0 after the last entry, so it is ready for the next sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = RF_READY;
        end else if (ClearReq) begin
            state_d = RF_CLEAR;
            cnt_d   = '0;
        end
        ready_d = state_d == RF_READY;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ClrEn   = state_q == RF_CLEAR;
    assign ClrAddr = cnt_q;
    assign Ready   = ready_q;

endmodule

// File: rtl/regfile_param_sb.sv
// regfile_param_sb: parametrised 2R/1W register file with optional zero register,
// write-to-read bypass, pending-write scoreboard and a self-clearing init sweep.
module regfile_param_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic                 IssueValid,
    input  logic [ADDR_BITS-1:0] IssueReg,
    output logic                 Busy1,
    output logic                 Busy2,
    input  logic                 ClearReq,
    output logic                 Ready
);

    localparam int DEPTH = rf_depth(ADDR_BITS);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]     busy_q, busy_d;
    logic                 clr_en;
    logic [ADDR_BITS-1:0] clr_addr;
    logic                 zero_wr, zero1, zero2, byp1, byp2, wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]     wr_data;

    regfile_init_seq #(.ADDR_BITS(ADDR_BITS)) u_init (
        .Clk     (Clk),
        .Reset   (Reset),
        .ClearReq(ClearReq),
        .ClrEn   (clr_en),
        .ClrAddr (clr_addr),
        .Ready   (Ready)
    );

    // The sweep owns the write port; a clear request discards that cycle's write.
    always_comb begin
        zero_wr = ZERO_REG != 0 && WriteRegister == '0;
        zero1   = ZERO_REG != 0 && ReadRegister1 == '0;
        zero2   = ZERO_REG != 0 && ReadRegister2 == '0;
        byp1    = BYPASS != 0 && RegWrite && Ready && WriteRegister == ReadRegister1 && !zero1;
        byp2    = BYPASS != 0 && RegWrite && Ready && WriteRegister == ReadRegister2 && !zero2;
        wr_en   = clr_en || (Ready && RegWrite && !ClearReq && !zero_wr);
        wr_addr = clr_en ? clr_addr : WriteRegister;
        wr_data = clr_en ? '0 : WriteData;
    end

    always_ff @(posedge Clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Issue is applied after the write-back clear so the newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (Ready && ClearReq) begin
            busy_d = '0;
        end else if (Ready) begin
            if (RegWrite) busy_d[WriteRegister] = 1'b0;
            if (IssueValid) busy_d[IssueReg] = 1'b1;
        end
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign ReadData1 = (!Ready || zero1) ? '0 : byp1 ? WriteData : mem_q[ReadRegister1];
    assign ReadData2 = (!Ready || zero2) ? '0 : byp2 ? WriteData : mem_q[ReadRegister2];
    assign Busy1     = Ready && busy_q[ReadRegister1] && !byp1;
    assign Busy2     = Ready && busy_q[ReadRegister2] && !byp2;

endmodule

// File: tb/tb_regfile_param_sb.sv
// tb_regfile_param_sb: scoreboard bench driving a bypassing and a non-bypassing instance in lockstep.
module tb_regfile_param_sb;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  rr1 = '0, rr2 = '0, wreg = '0, ireg = '0;
    logic [31:0] wdata = '0;
    logic        regwrite = 1'b0, ivalid = 1'b0, clrreq = 1'b0;
    logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        b1, b2, b1_nb, b2_nb, rdy, rdy_nb;

    localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_RDY = 4, S_CYC = 5,
                   S_RD1NB = 6, S_RD2NB = 7, S_B1NB = 8, S_B2NB = 9, S_RDYNB = 10;

    typedef struct {
        int          sig;
        logic [31:0] exp;
        int          meas;
        string       name;
    } exp_t;

    exp_t sb[$];
    event pushed;
    int   n_chk = 0, n_fail = 0, cyc = 0;

    always #5 Clk = ~Clk;

    regfile_param_sb #(.BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(rd1), .ReadData2(rd2),
        .WriteRegister(wreg), .WriteData(wdata), .RegWrite(regwrite),
        .IssueValid(ivalid), .IssueReg(ireg),
        .Busy1(b1), .Busy2(b2),
        .ClearReq(clrreq), .Ready(rdy)
    );

    regfile_param_sb #(.BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(rr1), .ReadRegister2(rr2),
        .ReadData1(rd1_nb), .ReadData2(rd2_nb),
        .WriteRegister(wreg), .WriteData(wdata), .RegWrite(regwrite),
        .IssueValid(ivalid), .IssueReg(ireg),
        .Busy1(b1_nb), .Busy2(b2_nb),
        .ClearReq(clrreq), .Ready(rdy_nb)
    );

    task automatic want(input int sig, input logic [31:0] exp, input string name);
        exp_t e;
        e.sig  = sig;
        e.exp  = exp;
        e.meas = cyc;
        e.name = name;
        sb.push_back(e);
        -> pushed;
    endtask

    function automatic logic [31:0] actual(input exp_t e);
        case (e.sig)
            S_RD1:   return rd1;
            S_RD2:   return rd2;
            S_B1:    return {31'd0, b1};
            S_B2:    return {31'd0, b2};
            S_RDY:   return {31'd0, rdy};
            S_CYC:   return 32'(e.meas);
            S_RD1NB: return rd1_nb;
            S_RD2NB: return rd2_nb;
            S_B1NB:  return {31'd0, b1_nb};
            S_B2NB:  return {31'd0, b2_nb};
            S_RDYNB: return {31'd0, rdy_nb};
            default: return 'x;
        endcase
    endfunction

    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(pushed);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = actual(e);
                n_chk++;
                if (a !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step(); settle();
        want(S_RDY, 0, "reset_ready");
        want(S_B1, 0, "reset_busy1");
        settle();
        Reset = 1'b0;
        cyc = 0;
        do begin step(); cyc++; end while (!rdy && cyc < 100);
        settle();
        want(S_CYC, 32, "init_sweep_len");
        want(S_RDYNB, 1, "init_ready_nb");
        settle();
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            rr2 = 5'(31 - i);
            settle();
            want(S_RD1, 0, "swept_rd1");
            want(S_RD2, 0, "swept_rd2");
            settle();
        end

        step(); regwrite = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF;
        step(); regwrite = 1'b0; rr1 = 5'd5; rr2 = 5'd5;
        settle();
        want(S_RD1, 32'hDEADBEEF, "r5_port1");
        want(S_RD2, 32'hDEADBEEF, "r5_port2");
        want(S_RD2NB, 32'hDEADBEEF, "r5_port2_nb");

        step(); regwrite = 1'b1; wreg = 5'd0; wdata = 32'h12345678; rr1 = 5'd0;
        settle();
        want(S_RD1, 0, "r0_no_bypass");
        step(); regwrite = 1'b0;
        settle();
        want(S_RD1, 0, "r0_after_write");
        want(S_RD1NB, 0, "r0_after_write_nb");

        step(); rr1 = 5'd7; regwrite = 1'b1; wreg = 5'd7; wdata = 32'hA5A5A5A5;
        settle();
        want(S_RD1, 32'hA5A5A5A5, "bypass_same_cycle");
        want(S_RD1NB, 0, "nobypass_old_value");
        step(); regwrite = 1'b0;
        settle();
        want(S_RD1NB, 32'hA5A5A5A5, "nobypass_next_cycle");
        want(S_RD1, 32'hA5A5A5A5, "r7_stored");

        step(); ivalid = 1'b1; ireg = 5'd9; rr1 = 5'd9; rr2 = 5'd9;
        settle();
        want(S_B1, 0, "busy_before_issue");
        step(); ivalid = 1'b0;
        settle();
        want(S_B1, 1, "busy1_issued");
        want(S_B2, 1, "busy2_issued");
        want(S_B2NB, 1, "busy2_issued_nb");
        step(); regwrite = 1'b1; wreg = 5'd9; wdata = 32'h99;
        settle();
        want(S_B1, 0, "busy_bypass_clear");
        want(S_B1NB, 1, "busy_nobypass_hold");
        step(); regwrite = 1'b0;
        settle();
        want(S_B1, 0, "busy_cleared");
        want(S_B1NB, 0, "busy_cleared_nb");
        step(); ivalid = 1'b1; ireg = 5'd9; regwrite = 1'b1; wreg = 5'd9; wdata = 32'h100;
        step(); ivalid = 1'b0; regwrite = 1'b0;
        settle();
        want(S_B1, 1, "busy_set_wins");
        step(); regwrite = 1'b1; wreg = 5'd9;
        step(); regwrite = 1'b0; ivalid = 1'b1; ireg = 5'd0; rr1 = 5'd0;
        step(); ivalid = 1'b0;
        settle();
        want(S_B1, 0, "busy_r0_never");

        step(); regwrite = 1'b1; wreg = 5'd3; wdata = 32'h55; ivalid = 1'b1; ireg = 5'd4;
        step(); regwrite = 1'b0; ivalid = 1'b0; rr1 = 5'd3; rr2 = 5'd4;
        settle();
        want(S_RD1, 32'h55, "r3_before_clear");
        want(S_B2, 1, "r4_busy_before_clear");
        step(); clrreq = 1'b1; regwrite = 1'b1; wreg = 5'd3; wdata = 32'h77; ivalid = 1'b1; ireg = 5'd4;
        step(); clrreq = 1'b0; regwrite = 1'b0; ivalid = 1'b0;
        settle();
        want(S_RDY, 0, "clear_ready_drop");
        want(S_B2, 0, "clear_busy_gated");
        cyc = 0;
        do begin
            step(); cyc++;
            if (cyc == 2) begin
                rr1 = 5'd5;
                settle();
                want(S_RD1, 0, "sweep_read_gated");
            end
            regwrite = cyc == 10;
            wreg = 5'd3;
            wdata = 32'hAB;
        end while (!rdy && cyc < 100);
        regwrite = 1'b0;
        settle();
        want(S_CYC, 32, "clear_sweep_len");
        settle();
        rr1 = 5'd3; rr2 = 5'd4;
        settle();
        want(S_RD1, 0, "clear_r3_zero");
        want(S_B2, 0, "clear_r4_not_busy");
        want(S_RD2, 0, "clear_r4_zero");

        step(); clrreq = 1'b1;
        step(); clrreq = 1'b0;
        cyc = 0;
        do begin step(); cyc++; end while (cyc < 10);
        Reset = 1'b1;
        settle();
        want(S_RDY, 0, "midreset_ready");
        step(); Reset = 1'b0;
        cyc = 0;
        do begin step(); cyc++; end while (!rdy && cyc < 100);
        settle();
        want(S_CYC, 32, "midreset_sweep_len");
        settle(); settle();
        n_chk++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL final_ready: got %b", rdy); end
        n_chk++;
        if (rdy_nb !== 1'b1) begin n_fail++; $display("FAIL final_ready_nb: got %b", rdy_nb); end
        n_chk++;
        if (b1 !== 1'b0) begin n_fail++; $display("FAIL final_busy1: got %b", b1); end
        n_chk++;
        if (rd1 !== 32'd0) begin n_fail++; $display("FAIL final_r3_zero: got %h", rd1); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_param_sb.md
Name: regfile_param_sb

Overview:
- Parametrised successor to the fixed 32x32 two-read/one-write register file; the CPU datapath instantiates it as its architectural register file.
- Adds configurable width and depth, an optional hardwired zero register, and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard for hazard detection.
- Adds a self-clearing init sequencer that zeroes every entry after reset or on request.

Parameters:
- WIDTH, 32, data bits per register.
- ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries.
- ZERO_REG, 1, when 1 entry 0 always reads 0, ignores writes, never becomes busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- Clk  in  1  system clock, posedge.
- Reset  in  1  asynchronous, active-high reset.
- ReadRegister1  in  ADDR_BITS  read port 1 address.
- ReadRegister2  in  ADDR_BITS  read port 2 address.
- ReadData1  out  WIDTH  read port 1 data.
- ReadData2  out  WIDTH  read port 2 data.
- WriteRegister  in  ADDR_BITS  write address.
- WriteData  in  WIDTH  write data.
- RegWrite  in  1  write enable, sampled at posedge.
- IssueValid  in  1  marks IssueReg as having a pending write.
- IssueReg  in  ADDR_BITS  destination being issued.
- Busy1  out  1  ReadRegister1 has a pending write.
- Busy2  out  1  ReadRegister2 has a pending write.
- ClearReq  in  1  request a full zeroing sweep.
- Ready  out  1  file is usable; 0 during a sweep.

Behaviour:
- FSM states: CLEAR and READY. Ready is registered and equals (state==READY).
- Reset asserted, asynchronously:
  - state=CLEAR, sweep counter=0, Ready=0, all busy bits=0.
  - Storage array is not reset directly.
- CLEAR state:
  - Each posedge writes 0 to entry[counter], then counter increments.
  - When counter==DEPTH-1 that entry is written and state goes to READY.
  - Sweep lasts exactly DEPTH cycles from reset release; Ready rises on the edge that writes the last entry.
  - RegWrite, IssueValid and ClearReq are ignored.
  - ReadData1/2=0, Busy1/2=0.
- READY state with ClearReq=1 at posedge:
  - Go to CLEAR, counter=0, all busy bits cleared.
  - Any RegWrite or IssueValid in that same cycle is discarded.
- Writes (READY only): at posedge, if RegWrite, entry[WriteRegister] gets WriteData, unless ZERO_REG=1 and WriteRegister==0.
- Reads:
  - Combinational: ReadDataN = entry[ReadRegisterN].
  - ZERO_REG=1 and address 0 -> 0.
  - BYPASS=1 and RegWrite and Ready and WriteRegister==ReadRegisterN and the target is not the zero register -> ReadDataN = WriteData in the same cycle.
  - BYPASS=0 -> the new value is visible one cycle after the write edge.
- Scoreboard (DEPTH busy bits, READY only):
  - At posedge, RegWrite clears busy[WriteRegister]; IssueValid sets busy[IssueReg].
  - IssueValid and RegWrite to the same register in the same cycle -> set wins (the newer producer).
  - ZERO_REG=1 -> busy[0] is held 0.
  - BusyN = busy[ReadRegisterN] & ~bypass_hitN, where bypass_hitN uses the same condition as data bypass and is forced 0 when BYPASS=0.
- Both read ports are fully independent; identical addresses on both ports are legal.
- Reset asserted mid-sweep restarts the sweep from counter 0.

Decomposition:
- Package regfile_pkg holds:
  - the state enum {RF_CLEAR, RF_READY};
  - the helper function computing DEPTH from ADDR_BITS.
- Sub-module regfile_init_seq (Clk, Reset, ClearReq, ClrEn, ClrAddr, Ready) holds the FSM and the sweep counter.
- The top module holds the storage, write muxing (sweep vs. RegWrite), bypass logic and scoreboard.

Test Plan:
- Reset, then release with ADDR_BITS=5 -> Ready=0 for exactly 32 cycles, then Ready=1; all 32 entries read 0 on both ports.
- Write 0xDEADBEEF to r5, then read r5 on port 1 and r5 on port 2 the next cycle -> both read 0xDEADBEEF. Writing 0x12345678 to r0 -> r0 reads 0.
- BYPASS=1: RegWrite r7=0xA5A5A5A5 with ReadRegister1=7 in the same cycle -> ReadData1=0xA5A5A5A5 combinationally. With BYPASS=0 -> old value that cycle, new value the next cycle.
- IssueValid r9 -> Busy1=1 for ReadRegister1=9. A later RegWrite r9 -> Busy1=0 in that cycle (BYPASS=1) and after the edge. IssueValid r9 with RegWrite r9 in the same cycle -> Busy stays 1.
- Write r3=0x55 and issue r4, then pulse ClearReq -> Ready drops the next cycle for 32 cycles; afterwards r3 reads 0 and Busy for r4 is 0. A RegWrite during the sweep has no effect.
- Assert Reset at sweep cycle 10 for 1 cycle -> the sweep restarts and Ready rises 32 cycles after Reset release.
